clock_enable_gen: RTL and testbench
===================================

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of clock-enable channels, legal 1..8; the block SHALL reject other values at elaboration.
REQ-002 Parameter DIV_W, default 16, divider width per channel, legal 2..32.
REQ-003 Parameter LOCK_FILTER, default 16, consecutive synchronised-lock cycles required before release, legal 1..255.
REQ-004 Parameter RST_HOLD, default 8, minimum cycles reset_out stays asserted after power-on reset, legal 1..255.
REQ-005 system_clock  input  1  single clock, all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 dcm_locked  input  1  DCM LOCKED, asynchronous to system_clock.
REQ-008 div_value  input  NUM_CH*DIV_W  per-channel divide-minus-one; channel k occupies bits [k*DIV_W +: DIV_W].
REQ-009 ch_enable  input  NUM_CH  per-channel run enable.
REQ-010 reset_out  output  1  active-high synchronous reset for downstream logic.
REQ-011 ready  output  1  high only in state RUN.
REQ-012 ce  output  NUM_CH  per-channel single-cycle clock-enable pulses.
REQ-013 loss_count  output  8  lock-loss event count; present only with CLKEN_LOSS_COUNT_EN.

Function
REQ-014 dcm_locked SHALL pass through a 2-flop synchroniser; lock_s denotes its output; all FSM decisions use lock_s only.
REQ-015 FSM states SHALL be HOLD, WAIT_LOCK, FILTER, RUN.
REQ-016 HOLD: count RST_HOLD cycles, then go to WAIT_LOCK; lock_s ignored.
REQ-017 WAIT_LOCK: go to FILTER when lock_s=1, filter counter cleared.
REQ-018 FILTER: increment filter counter while lock_s=1; lock_s=0 returns to WAIT_LOCK; reaching LOCK_FILTER consecutive high cycles goes to RUN.
REQ-019 RUN: lock_s=0 goes to WAIT_LOCK in the next cycle; reset_out asserts in that same next cycle.
REQ-020 reset_out SHALL be registered and equal 1 in every state except RUN; ready = not reset_out.
REQ-021 Each channel: counter cnt (DIV_W bits) and latched divisor div_l; in non-RUN states cnt=0, div_l=div_value slice, ce=0.
REQ-022 In RUN with ch_enable[k]=1: ce[k]=1 in the cycle cnt==div_l, cnt then wraps to 0 and div_l reloads from div_value; otherwise cnt increments, ce[k]=0.
REQ-023 div_value changes SHALL take effect only at wrap (no runt or stretched periods); period = div_l+1 cycles.
REQ-024 div_value slice = 0 SHALL give ce[k]=1 every cycle channel is enabled in RUN.
REQ-025 ch_enable[k]=0 SHALL force cnt=0, ce[k]=0, div_l reload each cycle; re-enable starts from cnt=0, first ce after div_l+1 cycles (cycle index div_l, 0-based).
REQ-026 On RUN entry all enabled channels SHALL start at cnt=0, so equal divisors produce phase-aligned ce.
REQ-027 ce SHALL be registered outputs; ce never asserts in a cycle where reset_out=1.

Reset
REQ-028 reset_n low SHALL asynchronously force: state HOLD, all counters 0, synchroniser flops 0, reset_out=1, ready=0, ce=0, loss_count=0.
REQ-029 reset_n deassertion mid-operation SHALL restart from HOLD irrespective of dcm_locked.

Configuration
REQ-030 Macro CLKEN_LOSS_COUNT_EN defined: loss_count port exists, increments by 1 on each RUN->WAIT_LOCK transition, saturates at 255, cleared only by reset_n.
REQ-031 Macro undefined: loss_count port and its counter absent; all other behaviour identical.

Verification
REQ-032 dcm_locked=1 constant, reset_n released at cycle 0, defaults -> reset_out=1 through HOLD(8)+WAIT_LOCK(1)+FILTER(16), ready=1 thereafter, no ce before ready.
REQ-033 RUN, div_value ch0=3, ch1=0, both enabled -> ce[0] every 4 cycles, first at RUN cycle 3; ce[1] every cycle from RUN cycle 0.
REQ-034 RUN, ch0 div 3 changed to 9 at cnt=1 -> remaining period completes at 4 cycles, subsequent periods 10 cycles.
REQ-035 dcm_locked pulses low 1 cycle during FILTER at count 10 -> returns to WAIT_LOCK, RUN reached only after 16 further consecutive high cycles.
REQ-036 Lock dropped 3 times in RUN (with CLKEN_LOSS_COUNT_EN) -> reset_out reasserts within 3 cycles of each drop, ce all 0, loss_count=3; 300 drops -> loss_count=255.
REQ-037 reset_n asserted mid-RUN with ce active -> reset_out=1, ce=0 immediately (asynchronous), HOLD sequence restarts on release.

Source files
------------

// File: rtl/clock_enable_gen_if.sv
// Clock-enable generator bus: per-channel divisor/enable in, status and
// clock-enable pulses out. Optional loss_count member when
// CLKEN_LOSS_COUNT_EN is defined.
interface clock_enable_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);
  logic [NUM_CH-1:0][DIV_W-1:0] div_value;
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            ce;
  logic                         reset_out;
  logic                         ready;
`ifdef CLKEN_LOSS_COUNT_EN
  logic [7:0]                   loss_count;

  modport master (output div_value, ch_enable,
                  input  ce, reset_out, ready, loss_count);
  modport slave  (input  div_value, ch_enable,
                  output ce, reset_out, ready, loss_count);
`else
  modport master (output div_value, ch_enable,
                  input  ce, reset_out, ready);
  modport slave  (input  div_value, ch_enable,
                  output ce, reset_out, ready);
`endif
endinterface

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: DCM-lock-qualified reset sequencer plus NUM_CH
// programmable clock-enable dividers.
//   HOLD -> WAIT_LOCK -> FILTER -> RUN; any synchronised lock loss drops
//   back to WAIT_LOCK and reasserts reset_out.
// Optional feature macro: CLKEN_LOSS_COUNT_EN adds the saturating
// loss_count output (RUN -> WAIT_LOCK events).
module clock_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD    = 8
) (
  input  logic              system_clock,
  input  logic              reset_n,
  input  logic              dcm_locked,
  clock_enable_gen_if.slave bus
);

  // Elaboration-time parameter range checks.
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("clock_enable_gen: NUM_CH=%0d outside 1..8", NUM_CH);
  end
  if (DIV_W < 2 || DIV_W > 32) begin : g_bad_div_w
    $error("clock_enable_gen: DIV_W=%0d outside 2..32", DIV_W);
  end
  if (LOCK_FILTER < 1 || LOCK_FILTER > 255) begin : g_bad_lock_filter
    $error("clock_enable_gen: LOCK_FILTER=%0d outside 1..255", LOCK_FILTER);
  end
  if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_rst_hold
    $error("clock_enable_gen: RST_HOLD=%0d outside 1..255", RST_HOLD);
  end

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_FILTER    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [7:0] FLT_LAST  = 8'(LOCK_FILTER - 1);

  state_e            state_q, state_d;
  logic              sync1_q, lock_s_q;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [7:0]        flt_cnt_q, flt_cnt_d;
  logic              reset_out_q, ready_q;
  logic              run_d;
  logic [NUM_CH-1:0] ce_w;

  // Two-flop synchroniser for the asynchronous DCM lock indication.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= dcm_locked;
      lock_s_q <= sync1_q;
    end
  end

  // Next-state logic; decisions look only at the synchronised lock.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    flt_cnt_d  = flt_cnt_q;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_WAIT_LOCK;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d   = S_FILTER;
          flt_cnt_d = 8'd0;
        end
      end
      S_FILTER: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (flt_cnt_q == FLT_LAST) begin
          state_d = S_RUN;
        end else begin
          flt_cnt_d = flt_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (!lock_s_q) state_d = S_WAIT_LOCK;
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign run_d = (state_d == S_RUN);

  // State and status registers; reset_out/ready follow the next state so
  // they line up exactly with the state they describe.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= 8'd0;
      flt_cnt_q   <= 8'd0;
      reset_out_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      flt_cnt_q   <= flt_cnt_d;
      reset_out_q <= !run_d;
      ready_q     <= run_d;
    end
  end

`ifdef CLKEN_LOSS_COUNT_EN
  logic [7:0] loss_q;

  // Saturating count of RUN -> WAIT_LOCK transitions.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= 8'd0;
    end else if (state_q == S_RUN && state_d == S_WAIT_LOCK && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.loss_count = loss_q;
`endif

  // Per-channel divider. The divisor is latched at start and at each wrap,
  // so a new div_value never produces a runt or stretched period. ce is
  // computed against the next state so it is never high while reset_out is.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [DIV_W-1:0] cnt_q, div_l_q;
    logic             ce_q;
    logic             active;

    assign active = run_d & bus.ch_enable[k];

    // Count toward the latched divisor, pulse and reload at wrap.
    always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        div_l_q <= '0;
        ce_q    <= 1'b0;
      end else if (active) begin
        if (cnt_q == div_l_q) begin
          ce_q    <= 1'b1;
          cnt_q   <= '0;
          div_l_q <= bus.div_value[k];
        end else begin
          ce_q    <= 1'b0;
          cnt_q   <= cnt_q + 1'b1;
        end
      end else begin
        ce_q    <= 1'b0;
        cnt_q   <= '0;
        div_l_q <= bus.div_value[k];
      end
    end

    assign ce_w[k] = ce_q;
  end

  assign bus.ce        = ce_w;
  assign bus.reset_out = reset_out_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: a cycle-level reference model
// pushes expected outputs each clock edge, a monitor pops and compares.
module tb_clock_enable_gen;
  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 16;
  localparam int LOCK_FILTER = 16;
  localparam int RST_HOLD    = 8;
  localparam int RUN_LAT     = RST_HOLD + 1 + LOCK_FILTER;

  logic system_clock = 1'b0;
  logic reset_n      = 1'b0;
  logic dcm_locked   = 1'b0;

  clock_enable_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clock_enable_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILTER(LOCK_FILTER), .RST_HOLD(RST_HOLD)
  ) dut (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .dcm_locked  (dcm_locked),
    .bus         (bus)
  );

  always #5 system_clock = ~system_clock;

  typedef struct packed {
    logic              rst;
    logic              rdy;
    logic [NUM_CH-1:0] ce;
    logic [7:0]        loss;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Run condition: after the hold window, the synchronised lock must have
  // been high for LOCK_FILTER+1 consecutive cycles (one WAIT_LOCK cycle plus
  // the filter). Each channel fires on an absolute schedule: next_fire is
  // the edge number of the next pulse.
  int                edge_n;
  int                consec;
  logic              ls_cur, dcm_prev, run_prev;
  int                next_fire [NUM_CH];
  logic              act_prev  [NUM_CH];
  int                div_prev  [NUM_CH];
  int                loss_m;

  always @(posedge system_clock) begin : model
    exp_t x;
    logic run_n;
    logic act;
    if (!reset_n) begin
      edge_n = 0; consec = 0; ls_cur = 0; dcm_prev = 0; run_prev = 0; loss_m = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        next_fire[k] = 0; act_prev[k] = 0; div_prev[k] = 0;
      end
      sbq.delete();
    end else begin
      edge_n++;
      if (edge_n - 1 >= RST_HOLD) consec = ls_cur ? consec + 1 : 0;
      run_n    = (consec >= LOCK_FILTER + 1);
      ls_cur   = dcm_prev;
      dcm_prev = dcm_locked;
      x.ce = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        act = run_n && bus.ch_enable[k];
        if (act) begin
          if (!act_prev[k]) next_fire[k] = edge_n + div_prev[k];
          if (edge_n == next_fire[k]) begin
            x.ce[k]      = 1'b1;
            next_fire[k] = edge_n + 1 + int'(bus.div_value[k]);
          end
        end
        act_prev[k] = act;
        div_prev[k] = int'(bus.div_value[k]);
      end
      if (run_prev && !run_n && loss_m < 255) loss_m++;
      run_prev = run_n;
      x.rst  = !run_n;
      x.rdy  = run_n;
      x.loss = 8'(loss_m);
      sbq.push_back(x);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge system_clock) begin : monitor
    exp_t x;
    if (!reset_n || sbq.size() == 0) begin
      x.rst = 1'b1; x.rdy = 1'b0; x.ce = '0; x.loss = 8'd0;
    end else begin
      x = sbq.pop_front();
    end
    check("reset_out", 32'(bus.reset_out), 32'(x.rst));
    check("ready",     32'(bus.ready),     32'(x.rdy));
    check("ce",        32'(bus.ce),        32'(x.ce));
`ifdef CLKEN_LOSS_COUNT_EN
    check("loss_count", 32'(bus.loss_count), 32'(x.loss));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string name, input int budget, output int at_edge);
    at_edge = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge system_clock);
      if (bus.ready === 1'b1) begin
        at_edge = edge_n;
        break;
      end
    end
    if (at_edge < 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: ready not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic release_reset();
    @(negedge system_clock);
    #2 reset_n = 1'b1;
  endtask

  // Asynchronous assert mid-cycle, immediate output check, then release.
  task automatic pulse_reset(input string name);
    @(negedge system_clock);
    #2 reset_n = 1'b0;
    #1;
    check({name, "_rst_async"},   32'(bus.reset_out), 32'd1);
    check({name, "_ready_async"}, 32'(bus.ready),     32'd0);
    check({name, "_ce_async"},    32'(bus.ce),        32'd0);
    repeat (3) @(negedge system_clock);
    #2 reset_n = 1'b1;
  endtask

  // One-cycle lock drop while running; reset_out must come back within 3.
  task automatic drop_lock(input string name);
    int seen;
    seen = 0;
    dcm_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge system_clock);
      if (i == 0) dcm_locked = 1'b1;
      if (bus.reset_out === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({name, "_rst_within3"}, 32'(seen), 32'd1);
    check({name, "_ce_off"}, 32'(bus.ce), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int at;
    dcm_locked   = 1'b1;
    bus.div_value[0] = 16'd3;
    bus.div_value[1] = 16'd0;
    bus.ch_enable    = 2'b11;
    #12;
    check("por_reset_out", 32'(bus.reset_out), 32'd1);
    check("por_ce",        32'(bus.ce),        32'd0);

    // Power-up with lock held high.
    release_reset();
    wait_ready("por_ready", 100, at);
    check("por_ready_cycle", 32'(at), 32'(RUN_LAT));
    repeat (20) @(negedge system_clock);

    // Change ch0 divisor mid-period; must take effect at the next wrap.
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
        @(negedge system_clock);
        if (bus.ce[0] === 1'b1) seen = 1;
      end
      check("ce0_seen", 32'(seen), 32'd1);
    end
    @(negedge system_clock);
    bus.div_value[0] = 16'd9;
    repeat (40) @(negedge system_clock);

    // One-cycle lock glitch at filter count 10.
    pulse_reset("glitch");
    bus.div_value[0] = 16'd3;
    begin
      int guard;
      guard = 0;
      while (edge_n != RST_HOLD + 1 + 10 - 2 && guard < 100) begin
        @(negedge system_clock);
        guard++;
      end
      check("glitch_sync", 32'(edge_n), 32'(RST_HOLD + 1 + 10 - 2));
    end
    dcm_locked = 1'b0;
    @(negedge system_clock);
    dcm_locked = 1'b1;
    wait_ready("glitch_ready", 100, at);
    check("glitch_ready_cycle", 32'(at), 32'(RST_HOLD + 1 + 10 + 2 + LOCK_FILTER));

    // Randomised lock drops, divisor changes and enable toggles.
    for (int i = 0; i < 3000; i++) begin
      @(negedge system_clock);
      dcm_locked = ($urandom_range(99) >= 2);
      if ($urandom_range(19) == 0)
        bus.div_value[$urandom_range(NUM_CH - 1)] = DIV_W'($urandom_range(6));
      if ($urandom_range(31) == 0)
        bus.ch_enable = NUM_CH'($urandom);
    end

    // Asynchronous reset while ce is active, then restart from HOLD.
    dcm_locked       = 1'b1;
    bus.div_value[1] = 16'd0;
    bus.ch_enable    = 2'b11;
    wait_ready("pre_async", 100, at);
    repeat (3) @(negedge system_clock);
    check("pre_async_ce1", 32'(bus.ce[1]), 32'd1);
    pulse_reset("midrun");
    wait_ready("post_async_ready", 100, at);
    check("post_async_ready_cycle", 32'(at), 32'(RUN_LAT));

    // Lock lost three times while running.
    for (int n = 0; n < 3; n++) begin
      repeat (5) @(negedge system_clock);
      drop_lock("drop");
      wait_ready("drop_relock", 100, at);
    end
`ifdef CLKEN_LOSS_COUNT_EN
    check("loss_count_3", 32'(bus.loss_count), 32'd3);
    for (int n = 3; n < 300; n++) begin
      @(negedge system_clock);
      drop_lock("sat_drop");
      wait_ready("sat_relock", 100, at);
    end
    check("loss_count_sat", 32'(bus.loss_count), 32'd255);
`endif
    repeat (5) @(negedge system_clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
